inst_fetch_ctrl: RTL

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl
//   Fetches a 4-byte big-endian instruction from a byte-wide synchronous
//   memory (one cycle read latency) at any byte alignment, and arbitrates
//   the memory port between the core's fetch path and a program loader.
//   The loader has priority, but only while the controller is idle.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/ready/adr    fetch request from the core
//   inst_valid/ready       instruction handshake towards the core
//   inst, inst_err         assembled instruction / out-of-range flag
//   ld_valid/ready         program-loader byte write handshake
//   ld_adr, ld_data        loader byte address and data
//   mem_adr, mem_rd        memory address and read strobe
//   mem_we, mem_wdata      memory write strobe and write byte
//   mem_rdata              memory read byte (one cycle after mem_rd)
module inst_fetch_ctrl #(
    parameter int Mbit = 32,
    parameter int size = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [Mbit-1:0] req_adr,
    output logic            req_ready,
    output logic            inst_valid,
    output logic [Mbit-1:0] inst,
    output logic            inst_err,
    input  logic            inst_ready,
    input  logic            ld_valid,
    input  logic [Mbit-1:0] ld_adr,
    input  logic [7:0]      ld_data,
    output logic            ld_ready,
    output logic [Mbit-1:0] mem_adr,
    output logic            mem_rd,
    output logic            mem_we,
    output logic [7:0]      mem_wdata,
    input  logic [7:0]      mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        HOLD
    } state_t;

    localparam logic [Mbit:0] SIZE_X = (Mbit+1)'(size);

    state_t          state, state_nx;
    logic [Mbit-1:0] base;
    logic [1:0]      cnt;
    logic [Mbit-1:0] inst_q;
    logic            err_q;

    logic [Mbit:0]   fetch_end;
    logic            fetch_ok;
    logic            ld_ok;
    logic            accept;

    // Range checks are done one bit wider so an address that wraps past
    // the top of the address space can never look in range.
    assign fetch_end = {1'b0, req_adr} + (Mbit+1)'(3);
    assign fetch_ok  = (fetch_end < SIZE_X);
    assign ld_ok     = ({1'b0, ld_adr} < SIZE_X);
    assign accept    = req_valid && req_ready;

    assign inst       = inst_q;
    assign inst_err   = err_q;
    assign inst_valid = (state == HOLD);

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        ld_ready  = 1'b0;
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                ld_ready  = 1'b1;
                req_ready = !ld_valid;
                if (ld_valid) begin
                    if (ld_ok) begin
                        mem_we    = 1'b1;
                        mem_adr   = ld_adr;
                        mem_wdata = ld_data;
                    end
                end else if (req_valid) begin
                    // An out-of-range fetch passes through DRAIN without
                    // capturing so it still reaches HOLD one edge later.
                    state_nx = fetch_ok ? READ : DRAIN;
                end
            end
            READ: begin
                mem_rd  = 1'b1;
                mem_adr = base + Mbit'(cnt);
                if (cnt == 2'd3) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                state_nx = HOLD;
            end
            HOLD: begin
                if (inst_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // Every strobe and handshake output is forced quiet during reset.
        if (!rst_n) begin
            req_ready = 1'b0;
            ld_ready  = 1'b0;
            mem_rd    = 1'b0;
            mem_we    = 1'b0;
            mem_adr   = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            base   <= '0;
            cnt    <= '0;
            inst_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        base   <= req_adr;
                        cnt    <= '0;
                        inst_q <= '0;
                        err_q  <= !fetch_ok;
                    end
                end
                READ: begin
                    cnt <= cnt + 2'd1;
                    // mem_rdata carries the byte addressed one cycle earlier,
                    // so nothing is captured in the first READ cycle.
                    if (cnt != 2'd0) begin
                        inst_q <= (inst_q << 8) | Mbit'(mem_rdata);
                    end
                end
                DRAIN: begin
                    if (!err_q) begin
                        inst_q <= (inst_q << 8) | Mbit'(mem_rdata);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
